bit_word_collector: RTL and testbench
=====================================

Name: bit_word_collector

Overview:
- Sits directly downstream of the push-button front end.
- Consumes its single-cycle logic0/logic1 pulses and its long-press flush pulse.
- Shifts bits MSB-first into an 8-bit word and pushes each completed word into a small first-word-fall-through FIFO.
- The FIFO is drained by the next stage (display/transmit logic) over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, 2..16.
- WORD_W, 8, bits per word.
- TIMEOUT, 249_999_999, idle cycles before a partial word is discarded (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- logic0  in  1  single-cycle pulse, bit value 0.
- logic1  in  1  single-cycle pulse, bit value 1.
- flush  in  1  single-cycle pulse from the long-press detector; clears all state.
- out_data  out  WORD_W  head-of-FIFO word; valid only when out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when out_valid & out_ready.
- partial  out  WORD_W  bits received so far, right-aligned, unused upper bits 0 (drives LEDs).
- bit_count  out  $clog2(WORD_W)+1  bits held in partial, 0..WORD_W-1.
- fifo_count  out  $clog2(DEPTH)+1  words stored, 0..DEPTH.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge):
  - partial=0, bit_count=0, fifo_count=0, out_valid=0, overflow=0.
  - out_data=0; pointers=0.
- Priority within a cycle: rst > flush > bit/pop activity.
- flush has the same effect as rst, but only in that cycle. Bit pulses and pops in the same cycle are ignored.
- Bit accept:
  - Exactly one of logic0/logic1 high: partial <= {partial[WORD_W-2:0], bit}; bit_count <= bit_count+1.
  - Both high in the same cycle: that cycle is ignored, with no state change.
- Word completion, on the WORD_W-th bit:
  - Word = {partial[WORD_W-2:0], bit}; the first received bit is the MSB.
  - Word is pushed into the FIFO; partial <= 0 and bit_count <= 0 in the same edge.
  - Latency: completing pulse at edge N; out_valid/out_data reflect the word after edge N (visible in cycle N+1) if the FIFO was empty.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH; fifo_count is tracked separately.
  - out_data is driven combinationally from mem[rd_ptr] (FWFT), zeroed when empty.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle: both occur and fifo_count is unchanged. This holds when the FIFO is full: the pop frees a slot, the push succeeds, and overflow is not set.
  - Push when full without a pop: the word is discarded, overflow <= 1, and the partial word is still cleared.
  - out_ready while empty: no effect.
- overflow clears only on rst/flush.
- No internal state machine beyond the shift counter and FIFO. The collector states are IDLE (bit_count=0) and COLLECTING (bit_count>0). The only return to IDLE is completion, flush, rst, or timeout.

Optional Feature:
- Macro: BIT_WORD_COLLECTOR_TIMEOUT_EN.
- Defined:
  - A 28-bit idle counter runs while bit_count>0.
  - It resets to 0 on every accepted bit.
  - When it reaches TIMEOUT, partial and bit_count clear to 0 at that edge. The FIFO and overflow are untouched.
  - An accepted bit at the same edge as the timeout wins: no clear, and the counter restarts.
- Undefined:
  - No counter is instantiated; a partial word is held indefinitely.
  - TIMEOUT is unused.

Decomposition:
- Shared package bwc_pkg holds:
  - WORD_W default;
  - the state encoding typedef (COLLECT_IDLE, COLLECT_BUSY);
  - the width helper constants for bit_count/fifo_count.
- One natural sub-module: word_fifo (parameterised DEPTH/WORD_W, push/pop/full/empty/count, FWFT output), instantiated once.
- The shift register, word-completion logic and timeout stay in the top.

Test Plan:
- Reset, then pulses 1,0,1,1,0,0,1,0 with out_ready=0:
  - out_data=8'hB2, out_valid=1 one cycle after the 8th pulse;
  - fifo_count=1; partial=0; bit_count=0.
- logic0 and logic1 asserted together for one cycle mid-word (bit_count=3):
  - partial and bit_count are unchanged.
- Fill with DEPTH=4 words 0x01..0x04, out_ready=0, then complete 0x05:
  - fifo_count stays 4; overflow=1; the head is still 0x01.
- FIFO full, and the 8th bit of 0xAA lands in the same cycle as out_ready=1:
  - 0x01 is popped, 0xAA is stored; fifo_count stays 4; overflow stays 0.
- Five bits received, 2 words stored, then a flush pulse coincident with a logic1 pulse:
  - next cycle: partial=0, bit_count=0, fifo_count=0, out_valid=0, overflow=0.
- Timeout build with TIMEOUT=20: send 3 bits, then idle 20 cycles:
  - bit_count returns to 0 exactly at the 20th idle edge; fifo_count is unchanged.
  - Without the macro, bit_count stays at 3.

Source files
------------

// File: rtl/bwc_pkg.sv
// ---------------------------------------------------------------------------
// bwc_pkg
// Shared definitions for the bit-to-word collector.
//   BWC_WORD_W      : default word width in bits
//   BWC_DEPTH       : default FIFO depth in words
//   collect_state_t : collector state (idle / collecting a partial word)
//   bwc_cnt_w()     : width of a counter that must hold the values 0..n
//   BWC_IDLE_CNT_W  : width of the optional idle (timeout) counter
// ---------------------------------------------------------------------------
package bwc_pkg;

    localparam int BWC_WORD_W     = 8;
    localparam int BWC_DEPTH      = 4;
    localparam int BWC_IDLE_CNT_W = 28;

    typedef enum logic {
        COLLECT_IDLE = 1'b0,
        COLLECT_BUSY = 1'b1
    } collect_state_t;

    // A counter holding 0..n needs one bit more than log2(n) when n is a power of two
    function automatic int bwc_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int BWC_BIT_CNT_W  = bwc_cnt_w(BWC_WORD_W);
    localparam int BWC_FIFO_CNT_W = bwc_cnt_w(BWC_DEPTH);

endpackage

// File: rtl/bit_word_collector_word_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo
// Small first-word-fall-through FIFO holding completed words.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous clear (empties the FIFO like rst)
//   push       : write push_data this cycle (ignored when full without a pop)
//   push_data  : word to write
//   pop        : remove the head word (ignored when empty)
//   head_data  : current head word, zero while empty
//   full       : DEPTH words stored
//   empty      : no words stored
//   count      : words stored, 0..DEPTH
// ---------------------------------------------------------------------------
module word_fifo
    import bwc_pkg::*;
#(
    parameter int DEPTH  = BWC_DEPTH,
    parameter int WORD_W = BWC_WORD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        push,
    input  logic [WORD_W-1:0]           push_data,
    input  logic                        pop,
    output logic [WORD_W-1:0]           head_data,
    output logic                        full,
    output logic                        empty,
    output logic [bwc_cnt_w(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = bwc_cnt_w(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_data is masked to zero while empty
    always_ff @(posedge clk) begin
        if (!rst && !clear && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bit_word_collector.sv
// ---------------------------------------------------------------------------
// bit_word_collector
// Collects single-bit pulses from the push-button front end MSB-first into
// WORD_W-bit words and queues completed words in a FWFT FIFO drained over a
// valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   logic0/1   : single-cycle bit pulses (both at once = ignored)
//   flush      : single-cycle pulse, clears all state like rst
//   out_data   : head-of-FIFO word (zero while empty)
//   out_valid  : FIFO non-empty
//   out_ready  : consumer takes the head word when out_valid & out_ready
//   partial    : bits received so far, right-aligned
//   bit_count  : bits held in partial, 0..WORD_W-1
//   fifo_count : words stored, 0..DEPTH
//   overflow   : sticky, a completed word was dropped on a full FIFO
// Optional build macro BIT_WORD_COLLECTOR_TIMEOUT_EN: discards a partial
// word after TIMEOUT idle cycles. Without it a partial word is held forever.
// ---------------------------------------------------------------------------
module bit_word_collector
    import bwc_pkg::*;
#(
    parameter int DEPTH   = BWC_DEPTH,
    parameter int WORD_W  = BWC_WORD_W,
    parameter int TIMEOUT = 249_999_999
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         logic0,
    input  logic                         logic1,
    input  logic                         flush,
    output logic [WORD_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            partial,
    output logic [bwc_cnt_w(WORD_W)-1:0] bit_count,
    output logic [bwc_cnt_w(DEPTH)-1:0]  fifo_count,
    output logic                         overflow
);

    localparam int BC_W = bwc_cnt_w(WORD_W);

    // Reject configurations the FIFO pointer arithmetic or idle counter cannot handle
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bit_word_collector: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT >= (1 << BWC_IDLE_CNT_W)) begin : g_bad_timeout
        $error("bit_word_collector: TIMEOUT must fit the idle counter");
    end

    logic [WORD_W-1:0] partial_q, partial_d;
    logic [BC_W-1:0]   bit_count_q, bit_count_d;
    logic              overflow_q, overflow_d;
    logic              bit_valid;
    logic              word_done;
    logic              timeout_hit;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] shifted;

    assign bit_valid = logic0 ^ logic1;
    assign word_done = bit_valid & (bit_count_q == BC_W'(WORD_W - 1));
    assign shifted   = {partial_q[WORD_W-2:0], logic1};
    assign pop       = ~fifo_empty & out_ready & ~flush;

    assign out_valid = ~fifo_empty;
    assign partial   = partial_q;
    assign bit_count = bit_count_q;
    assign overflow  = overflow_q;

`ifdef BIT_WORD_COLLECTOR_TIMEOUT_EN
    localparam logic [BWC_IDLE_CNT_W-1:0] IDLE_LAST = BWC_IDLE_CNT_W'(TIMEOUT - 1);

    collect_state_t            collect_state;
    logic [BWC_IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    assign collect_state = (bit_count_q != '0) ? COLLECT_BUSY : COLLECT_IDLE;

    // The edge that would take the counter to TIMEOUT is the one that discards the word
    assign timeout_hit = (collect_state == COLLECT_BUSY) && (idle_cnt_q == IDLE_LAST);

    // Idle counter only runs while a partial word is held; any accepted bit restarts it
    always_comb begin
        idle_cnt_d = idle_cnt_q + 1'b1;
        if (flush || bit_valid || timeout_hit || collect_state == COLLECT_IDLE) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Shift register and word completion; flush beats bits, bits beat timeout.
    // A completed word on a full FIFO is still cleared from partial, only the
    // FIFO refuses it, and a same-cycle pop makes room so no overflow occurs.
    always_comb begin
        partial_d   = partial_q;
        bit_count_d = bit_count_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        if (flush) begin
            partial_d   = '0;
            bit_count_d = '0;
            overflow_d  = 1'b0;
        end else if (bit_valid) begin
            if (word_done) begin
                push        = 1'b1;
                partial_d   = '0;
                bit_count_d = '0;
                if (fifo_full && !pop) begin
                    overflow_d = 1'b1;
                end
            end else begin
                partial_d   = shifted;
                bit_count_d = bit_count_q + 1'b1;
            end
        end else if (timeout_hit) begin
            partial_d   = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            partial_q   <= '0;
            bit_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            partial_q   <= partial_d;
            bit_count_q <= bit_count_d;
            overflow_q  <= overflow_d;
        end
    end

    word_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (shifted),
        .pop       (pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bit_word_collector.sv
// ---------------------------------------------------------------------------
// tb_bit_word_collector
// Self-checking bench for bit_word_collector. A queue holds the words the
// FIFO should contain; each pop compares the head word against it.
// ---------------------------------------------------------------------------
module tb_bit_word_collector;

    localparam int DEPTH   = 4;
    localparam int WORD_W  = 8;
    localparam int TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       logic0 = 1'b0;
    logic       logic1 = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] partial;
    logic [3:0] bit_count;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] m_partial = '0;
    int         m_count   = 0;
    logic       m_ovf     = 1'b0;

    bit_word_collector #(
        .DEPTH   (DEPTH),
        .WORD_W  (WORD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .logic0     (logic0),
        .logic1     (logic1),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .partial    (partial),
        .bit_count  (bit_count),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One clock with the given inputs; the model is advanced before the edge
    task automatic tick(input logic b0, input logic b1, input logic fl, input logic rdy);
        logic [7:0] w;
        logic0    = b0;
        logic1    = b1;
        flush     = fl;
        out_ready = rdy;
        if (fl) begin
            exp_q.delete();
            m_partial = '0;
            m_count   = 0;
            m_ovf     = 1'b0;
        end else begin
            if (rdy && exp_q.size() > 0) begin
                n_checks++;
                if (out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("[TB] FAIL pop_data: got %h expected %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (b0 ^ b1) begin
                if (m_count == WORD_W - 1) begin
                    w = {m_partial[6:0], b1};
                    if (exp_q.size() < DEPTH) exp_q.push_back(w);
                    else                      m_ovf = 1'b1;
                    m_partial = '0;
                    m_count   = 0;
                end else begin
                    m_partial = {m_partial[6:0], b1};
                    m_count++;
                end
            end
        end
        @(posedge clk);
        #1;
        logic0    = 1'b0;
        logic1    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 7; i >= 0; i--) begin
            tick(~w[i], w[i], 1'b0, rdy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_partial = '0;
        m_count   = 0;
        m_ovf     = 1'b0;
    endtask

    // Pops every queued word, checking out_valid before each pop
    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL drain_valid: got %b expected 1", out_valid);
            end
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL drain_empty: got valid=%b count=%0d expected 0/0", out_valid, fifo_count);
        end
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        n_checks++;
        if (partial !== 8'h00 || bit_count !== 4'd0 || fifo_count !== 3'd0 ||
            out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got p=%h bc=%0d fc=%0d v=%b o=%b d=%h expected all 0",
                     partial, bit_count, fifo_count, out_valid, overflow, out_data);
        end
    endtask

    task automatic test_basic_word();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        for (int i = 7; i >= 1; i--) tick(~pat[i], pat[i], 1'b0, 1'b0);
        n_checks++;
        if (partial !== 8'h59 || bit_count !== 4'd7) begin
            n_fail++;
            $display("[TB] FAIL seven_bits: got p=%h bc=%0d expected 59/7", partial, bit_count);
        end
        tick(~pat[0], pat[0], 1'b0, 1'b0);
        n_checks++;
        if (out_data !== 8'hB2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL word_b2: got d=%h v=%b expected b2/1", out_data, out_valid);
        end
        n_checks++;
        if (fifo_count !== 3'd1 || partial !== 8'h00 || bit_count !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL word_b2_state: got fc=%0d p=%h bc=%0d expected 1/00/0",
                     fifo_count, partial, bit_count);
        end
    endtask

    task automatic test_both_high();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (partial !== 8'h06 || bit_count !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL both_high: got p=%h bc=%0d expected 06/3", partial, bit_count);
        end
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (fifo_count !== 3'd2 || bit_count !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL both_high_word: got fc=%0d bc=%0d expected 2/0", fifo_count, bit_count);
        end
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
        n_checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fill: got fc=%0d o=%b expected 4/0", fifo_count, overflow);
        end
        send_word(8'h05, 1'b0);
        n_checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || out_data !== 8'h01) begin
            n_fail++;
            $display("[TB] FAIL overflow: got fc=%0d o=%b d=%h expected 4/1/01", fifo_count, overflow, out_data);
        end
        n_checks++;
        if (partial !== 8'h00 || bit_count !== 4'd0 || overflow !== m_ovf) begin
            n_fail++;
            $display("[TB] FAIL overflow_partial: got p=%h bc=%0d expected 00/0", partial, bit_count);
        end
        drain();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] pat;
        pat = 8'hAA;
        do_reset();
        for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
        for (int i = 7; i >= 1; i--) tick(~pat[i], pat[i], 1'b0, 1'b0);
        tick(~pat[0], pat[0], 1'b0, 1'b1);
        n_checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || out_data !== 8'h02) begin
            n_fail++;
            $display("[TB] FAIL full_push_pop: got fc=%0d o=%b d=%h expected 4/0/02", fifo_count, overflow, out_data);
        end
        drain();
    endtask

    task automatic test_flush();
        do_reset();
        send_word(8'h3C, 1'b0);
        send_word(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (fifo_count !== 3'd2 || bit_count !== 4'd5) begin
            n_fail++;
            $display("[TB] FAIL pre_flush: got fc=%0d bc=%0d expected 2/5", fifo_count, bit_count);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (partial !== 8'h00 || bit_count !== 4'd0 || fifo_count !== 3'd0 ||
            out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL flush: got p=%h bc=%0d fc=%0d v=%b o=%b d=%h expected all 0",
                     partial, bit_count, fifo_count, out_valid, overflow, out_data);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_word(8'h5A, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == TIMEOUT - 1) begin
                n_checks++;
                if (bit_count !== 4'd3) begin
                    n_fail++;
                    $display("[TB] FAIL idle_before_timeout: got %0d expected 3", bit_count);
                end
            end
        end
`ifdef BIT_WORD_COLLECTOR_TIMEOUT_EN
        m_partial = '0;
        m_count   = 0;
        n_checks++;
        if (bit_count !== 4'd0 || partial !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL timeout_clear: got bc=%0d p=%h expected 0/00", bit_count, partial);
        end
`else
        n_checks++;
        if (bit_count !== 4'd3 || partial !== 8'h06) begin
            n_fail++;
            $display("[TB] FAIL timeout_hold: got bc=%0d p=%h expected 3/06", bit_count, partial);
        end
`endif
        n_checks++;
        if (fifo_count !== 3'd1 || out_data !== 8'h5A) begin
            n_fail++;
            $display("[TB] FAIL timeout_fifo: got fc=%0d d=%h expected 1/5a", fifo_count, out_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom_range(0, 255));
            send_word(w, 1'b1);
            n_checks++;
            if (fifo_count !== 3'd1 || out_data !== w) begin
                n_fail++;
                $display("[TB] FAIL back_to_back: got fc=%0d d=%h expected 1/%h", fifo_count, out_data, w);
            end
        end
        drain();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_ovf: got %b expected 0", overflow);
        end
    endtask

    initial begin
        $display("[TB] start");
        @(negedge clk);
        test_reset();
        test_basic_word();
        test_both_high();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
